alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have req0_ready  output  1  requester 0 operation accepted this cycle when valid and ready both high.
REQ-006 SHALL have req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 SHALL have req0_op  input  3  requester 0 operation code.
REQ-008 SHALL have req1_valid, req1_ready, req1_a, req1_b, req1_op with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have rsp_valid  output  1  registered result available.
REQ-010 SHALL have rsp_ready  input  1  consumer takes the result when valid and ready both high.
REQ-011 SHALL have rsp_result  output  WIDTH  registered ALU result.
REQ-012 SHALL have rsp_zero  output  1  registered flag, high when rsp_result is all zeros.
REQ-013 SHALL have rsp_id  output  1  index of the requester that issued the held result.

Function
REQ-014 Op codes SHALL be 000 NOTHING, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT; 110/111 SHALL behave as NOTHING (result 0, zero 1).
REQ-015 ADD/SUB SHALL wrap modulo 2^WIDTH with no carry or overflow output; SLT SHALL yield 1 when bit WIDTH-1 of (a-b) is set, else 0.
REQ-016 can_accept SHALL equal (!rsp_valid || rsp_ready).
REQ-017 At most one of req0_ready/req1_ready SHALL be high in a cycle; each SHALL be low when can_accept is low.
REQ-018 Grant: only one valid -> that requester; both valid -> requester not granted last (round-robin); neither valid -> no ready.
REQ-019 The last-granted pointer SHALL update only on an accepted handshake.
REQ-020 Ready SHALL depend combinationally on valids, can_accept and the pointer; valids SHALL NOT depend on ready.
REQ-021 On acceptance in cycle N, rsp_valid/rsp_result/rsp_zero/rsp_id SHALL present the result in cycle N+1 (latency 1).
REQ-022 Output register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with simultaneous accept (new result loaded); FULL without drain holds all rsp_* stable.
REQ-023 Sustained throughput SHALL be one operation per cycle when rsp_ready is held high.
REQ-024 Operands SHALL be sampled only in the acceptance cycle; later changes on req*_a/b/op SHALL NOT affect the held result.

Reset
REQ-025 rst_n low SHALL immediately clear rsp_valid, rsp_result, rsp_zero, rsp_id to 0, and set the last-granted pointer to 1 so requester 0 wins the first contention.
REQ-026 Reset mid-operation SHALL discard any held result with no rsp handshake; ready outputs SHALL be low while rst_n is low.
REQ-027 Reset release SHALL be synchronous to clk; first acceptance is possible in the first cycle after release.

Structure
REQ-028 Op-code constants and a 2-state output-state enum SHALL live in a shared package alu_pkg.
REQ-029 The combinational ALU SHALL be one sub-module, alu_core (a, b, op -> result, zero), instantiated once and fed by the grant mux.
REQ-030 No other sub-modules; RTL size 120-400 lines including package.

Verification
REQ-031 Single: req0 ADD a=5 b=7, rsp_ready=1 -> next cycle rsp_valid=1, result=12, zero=0, id=0.
REQ-032 Contention: both valid every cycle, rsp_ready=1 -> grants 0,1,0,1...; req0 SUB 3-3 gives result 0, zero 1; req1 SLT 2,5 gives result 1.
REQ-033 Backpressure: rsp_ready=0 with result held -> both readies low, rsp_* stable 5 cycles; rsp_ready=1 -> drain plus same-cycle accept.
REQ-034 Wrap/illegal: ADD 0xFFFFFFFF+1 -> 0, zero 1; op 111 with a=9 -> result 0, zero 1; SLT 0x80000000,1 -> 0 (sign of wrapped difference clear).
REQ-035 Reset: assert rst_n low while rsp_valid=1 -> rsp_valid 0 without a clock edge; after release, both valid -> requester 0 granted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code constants and the output-register state type for the ALU arbiter.
// Imported by alu_core and alu_arbiter.
package alu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD/SUB wrap, SLT from the sign of the wrapped difference, other codes give 0.
// Zero latency, no flow control.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   logic [WIDTH-1:0] diff;

   assign diff = a - b;

   always_comb begin
      result = '0;
      case (op)
         OP_NOP:  result = '0;
         OP_ADD:  result = a + b;
         OP_SUB:  result = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to one ALU with a registered result; latency 1 from accept.
// Backpressure: readies drop while a held result is not being drained; full throughput with rsp_ready high.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_id
);

   out_state_e       state_q, state_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             id_q, id_d;

   logic             can_accept;
   logic             gnt0, gnt1;
   logic             accept;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [2:0]       alu_op;
   logic             alu_zero;

   assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

   // Pointer holds the last winner; on contention the other requester goes next.
   assign gnt0 = req0_valid && (!req1_valid || last_q);
   assign gnt1 = req1_valid && (!req0_valid || !last_q);

   // Readies are forced low while reset is asserted.
   assign req0_ready = rst_n && can_accept && gnt0;
   assign req1_ready = rst_n && can_accept && gnt1;
   assign accept     = req0_ready || req1_ready;

   assign alu_a  = gnt1 ? req1_a  : req0_a;
   assign alu_b  = gnt1 ? req1_b  : req0_b;
   assign alu_op = gnt1 ? req1_op : req0_op;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      result_d = result_q;
      zero_d   = zero_q;
      id_d     = id_q;

      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase

      if (accept) begin
         result_d = alu_result;
         zero_d   = alu_zero;
         id_d     = gnt1;
         last_d   = gnt1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         last_q   <= 1'b1;
         result_q <= '0;
         zero_q   <= 1'b0;
         id_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         id_q     <= id_d;
      end
   end

   assign rsp_valid  = (state_q == ST_FULL);
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses queued at grant time, checked by a separate monitor.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_id;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_id     (rsp_id)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic id, input logic [31:0] res);
      exp_t e;
      e.id   = id;
      e.res  = res;
      e.zero = (res == 32'd0);
      sb.push_back(e);
   endtask

   // One cycle: drive, check readies at negedge against hand-computed grants, queue the results.
   task automatic step(input logic rr,
                       input logic v0, input logic [2:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [31:0] e0,
                       input logic v1, input logic [2:0] op1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [31:0] e1,
                       input logic g0, input logic g1);
      rsp_ready  = rr;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      @(negedge clk);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
      if (g0) push_exp(1'b0, e0);
      if (g1) push_exp(1'b1, e1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rr);
      step(rr, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_held(input string nm, input logic [31:0] res, input logic id);
      chk({nm, "_valid"},  {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_result"}, rsp_result, res);
      chk({nm, "_zero"},   {31'd0, rsp_zero}, {31'd0, res == 32'd0});
      chk({nm, "_id"},     {31'd0, rsp_id}, {31'd0, id});
   endtask

   // Monitor: a response handshake completes at the next posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rsp: got result 0x%0h id %0d, expected no response", rsp_result, rsp_id);
            end else begin
               e = sb.pop_front();
               chk("rsp_id",     {31'd0, rsp_id},   {31'd0, e.id});
               chk("rsp_result", rsp_result,        e.res);
               chk("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
      #2;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_zero",   {31'd0, rsp_zero}, 32'd0);
      chk("rst_id",     {31'd0, rsp_id}, 32'd0);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: grants alternate starting with requester 0, one accept per cycle.
      step(1'b1, 1'b1, 3'b010, 32'd3, 32'd3, 32'd0,
                 1'b1, 3'b101, 32'd2, 32'd5, 32'd1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 3'b010, 32'd3, 32'd3, 32'd0,
                 1'b1, 3'b101, 32'd2, 32'd5, 32'd1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 3'b001, 32'd1, 32'd2, 32'd3,
                 1'b1, 3'b100, 32'hF0, 32'h0F, 32'hFF, 1'b1, 1'b0);
      step(1'b1, 1'b1, 3'b011, 32'hFF00, 32'h0FF0, 32'h0F00,
                 1'b1, 3'b101, 32'd5, 32'd2, 32'd0, 1'b0, 1'b1);
      idle(1'b1);

      // Single request, latency 1.
      step(1'b1, 1'b1, 3'b001, 32'd5, 32'd7, 32'd12,
                 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk_held("single", 32'd12, 1'b0);

      // Lone requester wins regardless of pointer; wrap, illegal op and SLT sign cases.
      step(1'b1, 1'b1, 3'b111, 32'd9, 32'd3, 32'd0,
                 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0,
                 1'b1, 3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0,
                 1'b1, 3'b101, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 3'b110, 32'd4, 32'd4, 32'd0,
                 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      idle(1'b1);

      // Backpressure: result held stable while operands on the inputs change.
      step(1'b0, 1'b1, 3'b001, 32'd10, 32'd20, 32'd30,
                 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 3'b010, 32'd100 + i, 32'd1, 32'd0,
                    1'b1, 3'b011, 32'hFFFF_FFFF, 32'h1234 + i, 32'd0, 1'b0, 1'b0);
         chk_held("hold", 32'd30, 1'b0);
      end
      step(1'b1, 1'b1, 3'b010, 32'd100, 32'd1, 32'd99,
                 1'b1, 3'b011, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 1'b0, 1'b1);
      step(1'b1, 1'b1, 3'b010, 32'd100, 32'd1, 32'd99,
                 1'b1, 3'b011, 32'hFFFF_FFFF, 32'h1234, 32'h1234, 1'b1, 1'b0);
      idle(1'b0);
      chk_held("pre_rst", 32'd99, 1'b0);

      // Mid-operation reset discards the held result without a clock edge.
      #2;
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("midrst_valid",  {31'd0, rsp_valid}, 32'd0);
      chk("midrst_result", rsp_result, 32'd0);
      chk("midrst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("midrst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("midrst_pending", sb.size(), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step(1'b1, 1'b1, 3'b001, 32'd2, 32'd2, 32'd4,
                 1'b1, 3'b010, 32'd2, 32'd5, 32'hFFFF_FFFD, 1'b1, 1'b0);
      step(1'b1, 1'b1, 3'b001, 32'd2, 32'd2, 32'd4,
                 1'b1, 3'b010, 32'd2, 32'd5, 32'hFFFF_FFFD, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
